// File: rtl/aes_cbc_sched.sv
// CBC/ECB block sequencer for aes_top: one block in flight, key strobe once per message, core-latency watchdog.
// Latency: s handshake to m_valid = core latency + 2; s_ready is low and no core start is issued while m_valid waits for m_ready.
module aes_cbc_sched #(
    parameter int BLK_W   = 128,
    parameter int KEY_W   = 128,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             msg_start,
    input  logic [KEY_W-1:0] msg_key,
    input  logic [BLK_W-1:0] msg_iv,
    input  logic             msg_cbc,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_data,
    output logic             m_last,
    output logic             core_en,
    output logic             core_key_strobe,
    output logic [KEY_W-1:0] core_key,
    output logic [BLK_W-1:0] core_plaintext,
    input  logic [BLK_W-1:0] core_ciphertext,
    input  logic             core_en_o,
    output logic             busy,
    output logic             err,
    output logic [31:0]      blk_cnt
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, OUT} state_t;

    state_t             state_q;
    logic [KEY_W-1:0]   key_q;
    logic [BLK_W-1:0]   chain_q;
    logic [BLK_W-1:0]   pt_q;
    logic [BLK_W-1:0]   ct_q;
    logic               cbc_q;
    logic               last_q;
    logic               key_pending_q;
    logic [WD_W-1:0]    wd_q;
    logic               err_q;
    logic [31:0]        cnt_q;
    logic               s_ready_q;
    logic               m_valid_q;
    logic               core_en_q;
    logic               strobe_q;
    logic               busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            key_q         <= '0;
            chain_q       <= '0;
            pt_q          <= '0;
            ct_q          <= '0;
            cbc_q         <= 1'b0;
            last_q        <= 1'b0;
            key_pending_q <= 1'b0;
            wd_q          <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            s_ready_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            core_en_q     <= 1'b0;
            strobe_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            core_en_q <= 1'b0;
            strobe_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (msg_start) begin
                        key_q         <= msg_key;
                        chain_q       <= msg_iv;
                        cbc_q         <= msg_cbc;
                        key_pending_q <= 1'b1;
                        cnt_q         <= '0;
                        err_q         <= 1'b0;
                        busy_q        <= 1'b1;
                        s_ready_q     <= 1'b1;
                        state_q       <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (s_valid) begin
                        pt_q      <= cbc_q ? (s_data ^ chain_q) : s_data;
                        last_q    <= s_last;
                        s_ready_q <= 1'b0;
                        core_en_q <= 1'b1;
                        strobe_q  <= key_pending_q;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    key_pending_q <= 1'b0;
                    wd_q          <= '0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    // wd_q counts WAIT cycles, so err rises exactly TIMEOUT cycles after core_en.
                    if (core_en_o) begin
                        ct_q      <= core_ciphertext;
                        chain_q   <= core_ciphertext;
                        cnt_q     <= cnt_q + 32'd1;
                        m_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end else if (wd_q == WD_W'(TIMEOUT - 2)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (last_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            s_ready_q <= 1'b1;
                            state_q   <= ACCEPT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready         = s_ready_q;
    assign m_valid         = m_valid_q;
    assign m_data          = ct_q;
    assign m_last          = last_q;
    assign core_en         = core_en_q;
    assign core_key_strobe = strobe_q;
    assign core_key        = key_q;
    assign core_plaintext  = pt_q;
    assign busy            = busy_q;
    assign err             = err_q;
    assign blk_cnt         = cnt_q;
endmodule

// File: tb/tb_aes_cbc_sched.sv
// Bench for aes_cbc_sched: behavioural core stand-in (known AES vectors plus a keyed mock),
// message table with expected values, scoreboard on the ciphertext stream, and hand-written corner sequences.
module tb_aes_cbc_sched;
    localparam int TIMEOUT = 64;
    localparam logic [127:0] KEY  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] B1   = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] B2   = 128'h12345678911123456789012345678901;
    localparam logic [127:0] CT1  = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] CT2  = 128'h2914b1466013ba1e48d6d795e97d3e15;
    localparam logic [127:0] PT2C = 128'h3BF70627C60503B327AB98905F655E3B;

    logic         clk = 1'b0, reset = 1'b0;
    logic         msg_start = 1'b0, msg_cbc = 1'b0;
    logic [127:0] msg_key = '0, msg_iv = '0;
    logic         s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [127:0] s_data = '0;
    logic         m_valid, m_ready = 1'b1, m_last;
    logic [127:0] m_data;
    logic         core_en, core_key_strobe;
    logic [127:0] core_key, core_plaintext;
    logic [127:0] core_ciphertext = '0;
    logic         core_en_o = 1'b0;
    logic         busy, err;
    logic [31:0]  blk_cnt;

    aes_cbc_sched #(.BLK_W(128), .KEY_W(128), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .msg_start(msg_start), .msg_key(msg_key), .msg_iv(msg_iv),
        .msg_cbc(msg_cbc), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_en(core_en), .core_key_strobe(core_key_strobe), .core_key(core_key),
        .core_plaintext(core_plaintext), .core_ciphertext(core_ciphertext), .core_en_o(core_en_o),
        .busy(busy), .err(err), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed { logic [127:0] pt; logic strobe; logic [127:0] key; } core_exp_t;
    typedef struct packed { logic [127:0] ct; logic last; } out_exp_t;
    core_exp_t    core_q[$];
    out_exp_t     sb_q[$];
    logic [127:0] pt_log[$], ct_log[$];

    int  core_lat  = 0;
    bit  core_mute = 1'b0;
    int  mv_seen   = 0;
    int  t_acc = 0, t_mv = 0;

    typedef struct {
        logic              cbc;
        logic [127:0]      key, iv;
        int                n;
        logic [2:0][127:0] blk;
        logic [127:0]      ct0, ct1, pt1;
        bit                ct0_v, ct1_v, pt1_v;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    // Stand-in core: real AES results for the known vectors, a keyed permutation otherwise.
    function automatic logic [127:0] core_f(input logic [127:0] pt, input logic [127:0] k);
        if (k == KEY && pt == B1) return CT1;
        if (k == KEY && pt == B2) return CT2;
        return {pt[63:0], pt[127:64]} ^ k ^ 128'h5A5A_0F0F_3C3C_A5A5_1234_8765_F00D_BEEF;
    endfunction

    function automatic vec_t mk(input logic c, input logic [127:0] k, input logic [127:0] iv, input int n,
                                input logic [127:0] b0, input logic [127:0] b1, input logic [127:0] b2,
                                input logic [127:0] e0, input bit e0v, input logic [127:0] e1, input bit e1v,
                                input logic [127:0] p1, input bit p1v);
        vec_t v;
        v.cbc = c; v.key = k; v.iv = iv; v.n = n;
        v.blk[0] = b0; v.blk[1] = b1; v.blk[2] = b2;
        v.ct0 = e0; v.ct0_v = e0v; v.ct1 = e1; v.ct1_v = e1v; v.pt1 = p1; v.pt1_v = p1v;
        return v;
    endfunction

    initial begin : core_model
        logic [127:0] key_lat, p;
        core_exp_t    e;
        int           lat;
        key_lat = '0;
        forever begin
            @(negedge clk);
            if (core_en === 1'b1) begin
                p = core_plaintext;
                if (core_key_strobe) key_lat = core_key;
                pt_log.push_back(p);
                if (core_q.size() == 0) begin
                    bound_fail("core_en_unexpected");
                end else begin
                    e = core_q.pop_front();
                    chk("core_plaintext", p, e.pt);
                    chk("core_key_strobe", {127'd0, core_key_strobe}, {127'd0, e.strobe});
                    chk("core_key", core_key, e.key);
                end
                if (!core_mute) begin
                    lat = (core_lat > 0) ? core_lat : int'($urandom_range(1, 4));
                    repeat (lat) @(posedge clk);
                    #1;
                    core_ciphertext = core_f(p, key_lat);
                    core_en_o = 1'b1;
                    @(posedge clk);
                    #1;
                    core_en_o = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        out_exp_t e;
        logic     mv_prev;
        mv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                mv_seen++;
                if (!mv_prev) t_mv = cyc;
            end
            mv_prev = m_valid;
            if (m_valid && m_ready) begin
                ct_log.push_back(m_data);
                if (sb_q.size() == 0) begin
                    bound_fail("m_valid_unexpected");
                end else begin
                    e = sb_q.pop_front();
                    chk("m_data", m_data, e.ct);
                    chk("m_last", {127'd0, m_last}, {127'd0, e.last});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {88'd0, s_ready, m_valid, m_last, core_en, core_key_strobe, busy, err, 1'b0, blk_cnt}, '0);
        chk({tag, "_m_data"}, m_data, '0);
        chk({tag, "_core_key"}, core_key, '0);
        chk({tag, "_core_pt"}, core_plaintext, '0);
    endtask

    task automatic start_msg(input logic c, input logic [127:0] k, input logic [127:0] iv);
        @(posedge clk); #1;
        msg_start = 1'b1; msg_key = k; msg_iv = iv; msg_cbc = c;
        @(posedge clk); #1;
        msg_start = 1'b0;
        @(negedge clk);
        chk("err_after_start", {127'd0, err}, '0);
        chk("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    task automatic send_blk(input logic [127:0] blk, input logic last, input logic c, input logic [127:0] k,
                            inout logic [127:0] chain, inout logic strobe, input bit push_out);
        logic [127:0] pt, ct;
        bit ok;
        pt = c ? (blk ^ chain) : blk;
        ct = core_f(pt, k);
        core_q.push_back('{pt: pt, strobe: strobe, key: k});
        if (push_out) sb_q.push_back('{ct: ct, last: last});
        chain  = ct;
        strobe = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = blk; s_last = last;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("s_ready_wait");
        else t_acc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic run_msg(input int idx);
        vec_t v;
        logic [127:0] chain;
        logic strobe;
        bit ok;
        v = tbl[idx];
        pt_log.delete();
        ct_log.delete();
        start_msg(v.cbc, v.key, v.iv);
        chain  = v.iv;
        strobe = 1'b1;
        for (int i = 0; i < v.n; i++)
            send_blk(v.blk[i], (i == v.n - 1), v.cbc, v.key, chain, strobe, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("busy_clear_wait");
        chk("blk_cnt", {96'd0, blk_cnt}, 128'(v.n));
        chk("busy_end", {127'd0, busy}, '0);
        if (v.ct0_v) chk("vec_ct0", ct_log.size() > 0 ? ct_log[0] : 'x, v.ct0);
        if (v.ct1_v) chk("vec_ct1", ct_log.size() > 1 ? ct_log[1] : 'x, v.ct1);
        if (v.pt1_v) chk("vec_core_pt1", pt_log.size() > 1 ? pt_log[1] : 'x, v.pt1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench stuck");
    end

    initial begin : main
        logic [127:0] chain, d0;
        logic strobe, l0;
        int mvs;
        bit ok;

        tbl[0] = mk(1'b1, KEY, '0, 1, B1, '0, '0, CT1, 1, '0, 0, '0, 0);
        tbl[1] = mk(1'b1, KEY, '0, 2, B1, B2, '0, CT1, 1, '0, 0, PT2C, 1);
        tbl[2] = mk(1'b0, KEY, '0, 2, B1, B2, '0, CT1, 1, CT2, 1, '0, 0);
        tbl[3] = mk(1'b1, 128'h000102030405060708090A0B0C0D0E0F, 128'hFEEDFACE_CAFEBABE_01234567_89ABCDEF, 3,
                    128'h11111111_22222222_33333333_44444444, 128'hDEADBEEF_00000000_FFFFFFFF_A5A5A5A5,
                    128'h0, '0, 0, '0, 0, '0, 0);
        tbl[4] = mk(1'b0, 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D, '0, 1, B2, '0, '0, '0, 0, '0, 0, '0, 0);

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;

        // Plaintext offered while IDLE must not be taken.
        s_valid = 1'b1; s_data = B1; s_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_s_ready", {127'd0, s_ready}, '0);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;

        for (int i = 0; i < 5; i++) run_msg(i);

        core_lat = 3;
        run_msg(0);
        chk("latency", 128'(t_mv - t_acc), 128'd5);
        core_lat = 0;

        // Output backpressure, with a stray msg_start that must not disturb the message.
        @(posedge clk); #1;
        m_ready = 1'b0;
        fork
            run_msg(1);
            begin
                ok = 1'b0;
                for (int n = 0; n < 300; n++) begin
                    @(negedge clk);
                    if (m_valid) begin ok = 1'b1; break; end
                end
                if (!ok) bound_fail("bp_m_valid_wait");
                d0 = m_data;
                l0 = m_last;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("bp_m_data", m_data, d0);
                    chk("bp_ctrl", {124'd0, m_valid, m_last, s_ready, core_en}, {124'd0, 1'b1, l0, 1'b0, 1'b0});
                    if (k == 3) begin msg_start = 1'b1; msg_key = ~KEY; end
                    if (k == 4) begin msg_start = 1'b0; msg_key = KEY; end
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join

        // Core never answers: watchdog fires, block dropped.
        core_mute = 1'b1;
        mvs = mv_seen;
        start_msg(1'b1, KEY, '0);
        chain = '0; strobe = 1'b1;
        send_blk(B1, 1'b1, 1'b1, KEY, chain, strobe, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (core_en) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("timeout_core_en_wait");
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("err_before_timeout", {127'd0, err}, '0);
        @(negedge clk);
        chk("err_at_timeout", {127'd0, err}, 128'd1);
        chk("busy_at_timeout", {127'd0, busy}, '0);
        core_mute = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_sticky", {127'd0, err}, 128'd1);
        chk("timeout_no_m_valid", 128'(mv_seen - mvs), '0);
        run_msg(2);

        // Reset while WAITing; the late core done must be ignored.
        core_lat = 8;
        start_msg(1'b1, KEY, 128'h1111);
        chain = 128'h1111; strobe = 1'b1;
        send_blk(B1, 1'b1, 1'b1, KEY, chain, strobe, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        mvs = mv_seen;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("late_done_no_m_valid", 128'(mv_seen - mvs), '0);
        chk("late_done_idle", {127'd0, busy}, '0);
        core_lat = 0;
        run_msg(3);

        repeat (5) @(negedge clk);
        chk("sb_drained", 128'(sb_q.size()), '0);
        chk("core_q_drained", 128'(core_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
